// File: rtl/jtgng_sys_ctrl.sv
// jtgng_sys_ctrl: merges reset sources into a held game_rst and aligns pause toggles to vblank start
module jtgng_sys_ctrl #(
  parameter int RST_CYCLES = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk_rgb,
  input  logic       rst,
  input  logic       LVBL,
  input  logic       downloading,
  input  logic       rst_req,
  input  logic       dip_flip,
  input  logic       key_reset,
  input  logic       key_pause,
  input  logic       joy_pause_b,
  output logic       game_rst,
  output logic       game_pause,
  output logic       pause_pend,
  output logic [1:0] st
);
  typedef enum logic [1:0] {RST_HOLD = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;
  state_t st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic game_rst_q, game_rst_d, game_pause_q, game_pause_d, pause_pend_q, pause_pend_d;
  logic last_dip_q, last_key_rst_q, last_key_pause_q, last_joy_b_q, last_lvbl_q;
  logic rsrc, ptog, vbs;
  assign rsrc = downloading | rst_req | (dip_flip != last_dip_q) | (key_reset & ~last_key_rst_q);
  assign ptog = (key_pause & ~last_key_pause_q) | (~joy_pause_b & last_joy_b_q);
  assign vbs  = ~LVBL & last_lvbl_q;
  // History regs track inputs every cycle, including during rst, so release raises no event
  always_ff @(posedge clk_rgb) begin
    last_dip_q       <= dip_flip;
    last_key_rst_q   <= key_reset;
    last_key_pause_q <= key_pause;
    last_joy_b_q     <= joy_pause_b;
    last_lvbl_q      <= LVBL;
  end
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      st_q         <= RST_HOLD;
      cnt_q        <= '0;
      game_rst_q   <= 1'b1;
      game_pause_q <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      game_rst_q   <= game_rst_d;
      game_pause_q <= game_pause_d;
      pause_pend_q <= pause_pend_d;
    end
  end
  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    game_rst_d   = game_rst_q;
    game_pause_d = game_pause_q;
    pause_pend_d = pause_pend_q;
    if (st_q == RST_HOLD) begin
      game_rst_d   = 1'b1;
      game_pause_d = 1'b0;
      pause_pend_d = 1'b0;
      cnt_d        = rsrc ? '0 : cnt_q + 1'b1;
      if (!rsrc && cnt_q == CNT_W'(RST_CYCLES - 1)) begin
        st_d       = RUN;
        cnt_d      = '0;
        game_rst_d = 1'b0;
      end
    end else if (rsrc) begin
      st_d         = RST_HOLD;
      cnt_d        = '0;
      game_rst_d   = 1'b1;
      game_pause_d = 1'b0;
      pause_pend_d = 1'b0;
    end else if (st_q == PEND) begin
      // A second toggle cancels the pending one, even on a vblank-start cycle
      if (ptog || vbs) begin
        st_d         = RUN;
        pause_pend_d = 1'b0;
        game_pause_d = ptog ? game_pause_q : ~game_pause_q;
      end
    end else if (ptog) begin
      st_d         = vbs ? RUN : PEND;
      pause_pend_d = ~vbs;
      game_pause_d = vbs ? ~game_pause_q : game_pause_q;
    end
  end
  assign game_rst   = game_rst_q;
  assign game_pause = game_pause_q;
  assign pause_pend = pause_pend_q;
  assign st         = st_q;
endmodule
